// File: rtl/rng_uart_pkg.sv
// Shared types and constants for the random-word UART drain.
package rng_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        HDR,
        SEND
    } drain_state_t;

    localparam logic [7:0] HDR_BYTE       = 8'hA5;
    localparam int         BYTES_PER_WORD = 8;
    localparam int         FRAME_BITS     = 10;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A start accepted on the same edge as done chains the
// next frame with no idle gap; done is combinational and marks the final stop-bit cycle.
module uart_byte_tx
    import rng_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic                  active;
    logic [CNT_W-1:0]      clk_cnt;
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-1:0] frame;
    logic                  bit_end;
    logic                  load;

    assign bit_end = active && (clk_cnt == CNT_MAX);
    assign done    = bit_end && (bit_idx == LAST_BIT);
    assign load    = start && (!active || done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else if (load) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
        end else if (bit_end) begin
            clk_cnt <= '0;
            if (done) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx      <= frame[1];
            end
        end else if (active) begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    // Frame shifter: bit 0 is always the bit currently on the line.
    always_ff @(posedge clk) begin
        if (load) begin
            frame <= {1'b1, data, 1'b0};
        end else if (bit_end) begin
            frame <= frame >> 1;
        end
    end

endmodule

// File: rtl/rng_uart_drain.sv
// Pops 64-bit words from the entropy FIFO and sends them LSB byte first as UART 8N1.
// Optional sync-byte prefix (0xA5) enabled by defining RNG_UART_HDR_EN.
module rng_uart_drain
    import rng_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [63:0] fifo_dout,
    output logic        tx,
    output logic        busy,
    output logic [15:0] word_cnt
);

    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

    drain_state_t state;
    logic [63:0]  sr;
    logic [2:0]   byte_idx;
    logic         start;
    logic [7:0]   data;
    logic         done;

    // Next frame is launched on the edge the previous one finishes, so bytes run back-to-back.
    always_comb begin
        start = 1'b0;
        data  = sr[7:0];
        case (state)
            LATCH: begin
                start = 1'b1;
`ifdef RNG_UART_HDR_EN
                data  = HDR_BYTE;
`else
                data  = fifo_dout[7:0];
`endif
            end
            HDR: begin
                start = done;
                data  = sr[7:0];
            end
            SEND: begin
                start = done && (byte_idx != LAST_BYTE);
                data  = sr[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == LATCH) begin
            sr <= fifo_dout;
        end else if (state == SEND && done) begin
            sr <= sr >> 8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            word_cnt   <= '0;
            byte_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !fifo_empty) begin
                        state      <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                POP: begin
                    fifo_rd_en <= 1'b0;
                    state      <= LATCH;
                end
                LATCH: begin
                    byte_idx <= '0;
`ifdef RNG_UART_HDR_EN
                    state    <= HDR;
`else
                    state    <= SEND;
`endif
                end
                HDR: begin
                    if (done) state <= SEND;
                end
                SEND: begin
                    if (done) begin
                        if (byte_idx == LAST_BYTE) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            word_cnt <= word_cnt + 16'd1;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    fifo_rd_en <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .data (data),
        .tx   (tx),
        .done (done)
    );

endmodule

// File: tb/tb_rng_uart_drain.sv
// Directed bench for rng_uart_drain: FIFO model, UART line decoder, hand-checked words.
module tb_rng_uart_drain;

    localparam int CPB = 4;
`ifdef RNG_UART_HDR_EN
    localparam int NF = 9;
`else
    localparam int NF = 8;
`endif
    localparam int HDR_FR = NF - 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [63:0] fifo_dout = '0;
    logic        tx;
    logic        busy;
    logic [15:0] word_cnt;

    rng_uart_drain #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .tx        (tx),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: pushed by the stimulus process, popped here on fifo_rd_en.
    logic [63:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_pulses = 0;
    int underflow = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (rd_ptr != wr_ptr) begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
    end

    // Line decoder, sampled on the falling edge; frames are logged only once complete.
    logic [7:0] rx_q[$];
    int starts[$];
    int ends[$];
    int ncyc = 0;
    int stop_err = 0;
    int tx_low = 0;

    initial begin : decoder
        int cnt;
        int t0;
        bit act;
        logic [7:0] sh;
        cnt = 0;
        t0 = 0;
        act = 1'b0;
        sh = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (tx == 1'b0) tx_low++;
            if (rst) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx == 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                    t0  = ncyc;
                end
            end else begin
                cnt++;
                if (cnt % CPB == CPB / 2 && cnt >= CPB + CPB / 2 && cnt <= 8 * CPB + CPB / 2)
                    sh = {tx, sh[7:1]};
                if (cnt == 9 * CPB + CPB / 2 && tx !== 1'b1) stop_err++;
                if (cnt == 10 * CPB - 1) begin
                    act = 1'b0;
                    rx_q.push_back(sh);
                    starts.push_back(t0);
                    ends.push_back(ncyc);
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_wc(input logic [15:0] target, input int budget);
        for (int i = 0; i < budget && word_cnt !== target; i++) @(negedge clk);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    endtask

    // Compares NF decoded frames starting at frame index base against one word.
    task automatic chk_word(input string tag, input int base, input logic [63:0] w);
        logic [7:0] e;
        chk({tag, "_nfr"}, 64'(rx_q.size() >= base + NF), 64'd1);
        if (rx_q.size() >= base + NF) begin
            for (int j = 0; j < NF; j++) begin
                if (j < HDR_FR) e = 8'hA5;
                else e = 8'(w >> (8 * (j - HDR_FR)));
                chk($sformatf("%s_b%0d", tag, j), 64'(rx_q[base + j]), 64'(e));
            end
        end
    endtask

    initial begin
        int rb;
        int pb;
        int g;
        logic [63:0] w3 [0:2];
        w3[0] = 64'h1122334455667788;
        w3[1] = 64'hDEADBEEFCAFEF00D;
        w3[2] = 64'h00FF00FF5AA5C33C;

        // Reset state
        idle_cycles(3);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd", 64'(fifo_rd_en), 64'd0);
        chk("rst_wc", 64'(word_cnt), 64'd0);
        #1 rst = 1'b0;
        idle_cycles(2);

        // Single word
        rb = rx_q.size();
        pb = rd_pulses;
        push(64'h0807060504030201);
        en = 1'b1;
        wait_wc(16'd1, 1000);
        en = 1'b0;
        chk("w1_wc", 64'(word_cnt), 64'd1);
        chk("w1_pulses", 64'(rd_pulses - pb), 64'd1);
        chk_word("w1", rb, 64'h0807060504030201);
        if (ends.size() >= rb + NF)
            chk("w1_dur", 64'(ends[rb + NF - 1] - starts[rb] + 1), 64'(NF * 10 * CPB));
        chk("w1_busy", 64'(busy), 64'd0);

        // Three words back to back
        idle_cycles(5);
        rb = rx_q.size();
        pb = rd_pulses;
        for (int k = 0; k < 3; k++) push(w3[k]);
        en = 1'b1;
        wait_wc(16'd4, 4000);
        idle_cycles(50);
        chk("w3_wc", 64'(word_cnt), 64'd4);
        chk("w3_pulses", 64'(rd_pulses - pb), 64'd3);
        chk("w3_empty", 64'(fifo_empty), 64'd1);
        for (int k = 0; k < 3; k++) chk_word($sformatf("w3_%0d", k), rb + k * NF, w3[k]);
        for (int k = 0; k < 2; k++) begin
            if (ends.size() >= rb + 3 * NF) begin
                g = starts[rb + (k + 1) * NF] - ends[rb + k * NF + NF - 1] - 1;
                chk($sformatf("w3_gap%0d", k), 64'(g), 64'd3);
            end
        end
        en = 1'b0;

        // en dropped during byte 3, two words queued
        idle_cycles(5);
        rb = rx_q.size();
        pb = rd_pulses;
        push(64'h0123456789ABCDEF);
        push(64'hF0E1D2C3B4A59687);
        en = 1'b1;
        wait_bytes(rb + HDR_FR + 3, 1000);
        en = 1'b0;
        for (int i = 0; i < 1000 && busy !== 1'b0; i++) @(negedge clk);
        idle_cycles(50);
        chk("en_wc", 64'(word_cnt), 64'd5);
        chk("en_pulses", 64'(rd_pulses - pb), 64'd1);
        chk("en_frames", 64'(rx_q.size() - rb), 64'(NF));
        chk_word("en", rb, 64'h0123456789ABCDEF);
        chk("en_busy", 64'(busy), 64'd0);
        chk("en_tx", 64'(tx), 64'd1);

        // rst during byte 5, then the next queued word from byte 0
        rb = rx_q.size();
        pb = rd_pulses;
        push(64'h5A5A5A5A3C3C3C3C);
        en = 1'b1;
        wait_bytes(rb + HDR_FR + 5, 1000);
        #1 rst = 1'b1;
        #1;
        chk("ar_tx", 64'(tx), 64'd1);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_wc", 64'(word_cnt), 64'd0);
        chk("ar_pulses", 64'(rd_pulses - pb), 64'd1);
        idle_cycles(3);
        #1 rst = 1'b0;
        rb = rx_q.size();
        pb = rd_pulses;
        wait_wc(16'd1, 1000);
        en = 1'b0;
        chk("ar_wc2", 64'(word_cnt), 64'd1);
        chk("ar_pulses2", 64'(rd_pulses - pb), 64'd1);
        chk_word("ar", rb, 64'h5A5A5A5A3C3C3C3C);

        // Empty FIFO with en held high
        idle_cycles(5);
        pb = rd_pulses;
        g = tx_low;
        en = 1'b1;
        idle_cycles(100);
        chk("emp_pulses", 64'(rd_pulses - pb), 64'd0);
        chk("emp_txlow", 64'(tx_low - g), 64'd0);
        chk("emp_busy", 64'(busy), 64'd0);
        en = 1'b0;

        chk("stop_bits", 64'(stop_err), 64'd0);
        chk("underflow", 64'(underflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
